rev_alu_seq: RTL and testbench



---
 rtl/rev_alu_pkg.sv | 33 +++
 rtl/rev_digit_adder.sv | 28 ++
 rtl/rev_alu_seq.sv | 153 +++++++++++++++
 tb/tb_rev_alu_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rev_alu_pkg.sv
// rtl/rev_alu_pkg.sv - opcodes, FSM states and opcode helpers for the sequential reversible ALU
package rev_alu_pkg;

   typedef enum logic [3:0] {
      OP_XOR     = 4'd0,
      OP_NOT     = 4'd1,
      OP_AND     = 4'd2,
      OP_NAND    = 4'd3,
      OP_OR      = 4'd4,
      OP_NOR     = 4'd5,
      OP_FREDKIN = 4'd6,
      OP_PERES   = 4'd7,
      OP_ADD     = 4'd8,
      OP_SUB     = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

   function automatic logic is_arith(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op > OP_LAST_LEGAL;
   endfunction

endpackage

// File: rtl/rev_digit_adder.sv
// rtl/rev_digit_adder.sv - DIGIT-bit ripple adder, each full adder built from two Peres gates
module rev_digit_adder #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout
);

   logic [DIGIT:0] cy;

   assign cy[0] = cin;

   // Peres(x,y,0) gives x^y and x&y; Peres(x^y,cin,x&y) gives sum and carry.
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      logic q1;
      logic r1;
      assign q1        = x[i] ^ y[i];
      assign r1        = x[i] & y[i];
      assign s[i]      = q1 ^ cy[i];
      assign cy[i+1]   = (q1 & cy[i]) ^ r1;
   end

   assign cout = cy[DIGIT];

endmodule

// File: rtl/rev_alu_seq.sv
// rtl/rev_alu_seq.sv - handshaked reversible-gate ALU; bitwise ops in one cycle, ADD/SUB digit-serial
module rev_alu_seq
   import rev_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             err
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(NDIG - 1);
   localparam logic [WIDTH-1:0] DMASK    = WIDTH'({DIGIT{1'b1}});

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] bw_res;
   logic [31:0]      sh;
   logic [DIGIT-1:0] dig_x, dig_y, dig_s;
   logic             dig_cout;

   // Bitwise ops phrased as the reversible gate that produces them.
   always_comb begin
      bw_res = '0;
      case (op_q)
         OP_XOR:     bw_res = a_q ^ b_q;
         OP_NOT:     bw_res = a_q ^ {WIDTH{1'b1}};
         OP_AND:     bw_res = (a_q & b_q) ^ {WIDTH{1'b0}};
         OP_NAND:    bw_res = (a_q & b_q) ^ {WIDTH{1'b1}};
         OP_OR:      bw_res = (a_q & b_q) ^ a_q ^ b_q;
         OP_NOR:     bw_res = ~((a_q & b_q) ^ a_q ^ b_q);
         OP_FREDKIN: bw_res = (b_q & c_q) | (a_q & ~c_q);
         OP_PERES:   bw_res = (a_q & b_q) ^ c_q;
         default:    bw_res = '0;
      endcase
   end

   // SUB feeds ~b through a Feynman NOT; carry register was preset to 1.
   always_comb begin
      sh    = 32'(cnt_q) * 32'(DIGIT);
      dig_x = DIGIT'(a_q >> sh);
      dig_y = DIGIT'(b_q >> sh) ^ {DIGIT{op_q == OP_SUB}};
   end

   rev_digit_adder #(
      .DIGIT (DIGIT)
   ) u_adder (
      .x    (dig_x),
      .y    (dig_y),
      .cin  (carry_q),
      .s    (dig_s),
      .cout (dig_cout)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d     = op;
               a_d      = a;
               b_d      = b;
               c_d      = c;
               cnt_d    = '0;
               carry_d  = (op == OP_SUB);
               err_d    = 1'b0;
               result_d = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (is_arith(op_q)) begin
               result_d = (result_q & ~(DMASK << sh)) | (WIDTH'(dig_s) << sh);
               carry_d  = dig_cout;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               result_d = bw_res;
               err_d    = is_illegal(op_q);
               carry_d  = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign carry_out = carry_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rev_alu_seq.sv
// tb/tb_rev_alu_seq.sv - directed self-checking bench for rev_alu_seq
module tb_rev_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a, b, c;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry_out;
   logic        err;

   int total = 0;
   int bad   = 0;
   int lat;

   rev_alu_seq #(.WIDTH(32), .DIGIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Presents one request, returns edges from accept edge (inclusive) to out_valid.
   task automatic run(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [31:0] xc, output int edges);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = xa; b = xb; c = xc;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; c = $urandom;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; c = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // XOR with latency
      run(4'd0, 32'hAAAAAAAA, 32'h55555555, 32'h0, lat);
      chk("xor_lat", lat, 2);
      chk("xor_res", result, 32'hFFFFFFFF);
      chk("xor_carry", carry_out, 0);
      chk("xor_err", err, 0);
      handshake();
      chk("xor_idle_out_valid", out_valid, 0);
      chk("xor_idle_in_ready", in_ready, 1);

      run(4'd6, 32'h12345678, 32'h9ABCDEF0, 32'h87654321, lat);
      chk("fredkin_res", result, 32'h92345678);
      chk("fredkin_err", err, 0);
      handshake();

      run(4'd1, 32'h12345678, 32'h0, 32'h0, lat);
      chk("not_res", result, 32'hEDCBA987);
      handshake();

      run(4'd5, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, lat);
      chk("nor_res", result, 32'h00000F0F);
      handshake();

      run(4'd8, 32'hFFFFFFFF, 32'h00000001, 32'h0, lat);
      chk("add_lat", lat, 5);
      chk("add_res", result, 32'h00000000);
      chk("add_carry", carry_out, 1);
      handshake();

      run(4'd8, 32'h000000FF, 32'h00000001, 32'h0, lat);
      chk("add_ripple_res", result, 32'h00000100);
      chk("add_ripple_carry", carry_out, 0);
      handshake();

      run(4'd9, 32'h00000000, 32'h00000001, 32'h0, lat);
      chk("sub_lat", lat, 5);
      chk("sub_res", result, 32'hFFFFFFFF);
      chk("sub_borrow", carry_out, 0);
      handshake();

      run(4'd9, 32'h00000005, 32'h00000003, 32'h0, lat);
      chk("sub_pos_res", result, 32'h00000002);
      chk("sub_pos_carry", carry_out, 1);
      handshake();

      run(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, lat);
      chk("peres_res", result, 32'hFFFFFFFF);
      handshake();

      run(4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h87654321, lat);
      chk("illegal_lat", lat, 2);
      chk("illegal_res", result, 32'h0);
      chk("illegal_err", err, 1);
      chk("illegal_carry", carry_out, 0);
      chk("illegal_in_ready", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("illegal_hold_in_ready", in_ready, 0);
      chk("illegal_hold_err", err, 1);
      handshake();
      chk("illegal_after_in_ready", in_ready, 1);

      // Backpressure
      run(4'd8, 32'h80000000, 32'h80000001, 32'h0, lat);
      for (int i = 0; i < 3; i++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_res", result, 32'h00000001);
         chk("bp_carry", carry_out, 1);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk);
         @(negedge clk);
      end
      handshake();
      chk("bp_release_out_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);

      // Reset in the second BUSY cycle of an ADD
      @(negedge clk);
      in_valid = 1'b1; op = 4'd8; a = 32'h01010101; b = 32'h01010101;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_res", result, 0);
      chk("abort_carry", carry_out, 0);
      chk("abort_err", err, 0);
      chk("abort_in_ready", in_ready, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end

      run(4'd0, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0, lat);
      chk("post_abort_lat", lat, 2);
      chk("post_abort_res", result, 32'hF0F00F0F);
      handshake();

      // in_valid together with rst: nothing is accepted
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'h1; b = 32'h2;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_valid_no_out", out_valid, 0);
      end
      chk("rst_valid_in_ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
